// File: rtl/reg_sched_if.sv
// Bundled CPU, debug-port and register-file signals for reg_sched.
// master drives the CPU/debug requests and regs read data; slave is the scheduler.
`ifndef REG_SCHED_DEFS
`define REG_SCHED_DEFS
`define REG_ADDR_SIZE 3
`define REG_SIZE      8
`define CYCLE_SIZE    4
`define CYCLE_FETCH   4'b0001
`define CYCLE_DECODE1 4'b0010
`define CYCLE_DECODE2 4'b0100
`define CYCLE_EXECUTE 4'b1000
`define REG_Z_ADDR    0
`define REG_R1_ADDR   1
`define REG_SW07_ADDR 6
`define REG_SW8_ADDR  7
`endif

interface reg_sched_if #(
  parameter int ADDR_W = `REG_ADDR_SIZE,
  parameter int DATA_W = `REG_SIZE
);
  logic [ADDR_W-1:0]      cpu_reg1_addr;
  logic [ADDR_W-1:0]      cpu_reg2_addr;
  logic [ADDR_W-1:0]      cpu_wr_addr;
  logic [DATA_W-1:0]      cpu_wr_data;
  logic                   cpu_wr_en;
  logic                   dbg_req;
  logic                   dbg_we;
  logic [ADDR_W-1:0]      dbg_addr;
  logic [DATA_W-1:0]      dbg_wdata;
  logic                   dbg_ack;
  logic                   dbg_err;
  logic [DATA_W-1:0]      dbg_rdata;
  logic [ADDR_W-1:0]      reg1_addr;
  logic [ADDR_W-1:0]      reg2_addr;
  logic [ADDR_W-1:0]      wr_addr;
  logic [DATA_W-1:0]      wr_data;
  logic                   wr_en;
  logic [DATA_W-1:0]      reg_1;
  logic [`CYCLE_SIZE-1:0] cycle;

  modport master (
    output cpu_reg1_addr, cpu_reg2_addr, cpu_wr_addr, cpu_wr_data, cpu_wr_en,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, reg_1,
    input  dbg_ack, dbg_err, dbg_rdata, reg1_addr, reg2_addr, wr_addr, wr_data,
    input  wr_en, cycle
  );

  modport slave (
    input  cpu_reg1_addr, cpu_reg2_addr, cpu_wr_addr, cpu_wr_data, cpu_wr_en,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, reg_1,
    output dbg_ack, dbg_err, dbg_rdata, reg1_addr, reg2_addr, wr_addr, wr_data,
    output wr_en, cycle
  );
endinterface

// File: rtl/reg_sched.sv
// Time-shares the register file between the CPU phase sequence and a debug port;
// one debug slot (2 cycles) may follow each EXECUTE, requests wait until then.
`ifndef REG_SCHED_DEFS
`define REG_SCHED_DEFS
`define REG_ADDR_SIZE 3
`define REG_SIZE      8
`define CYCLE_SIZE    4
`define CYCLE_FETCH   4'b0001
`define CYCLE_DECODE1 4'b0010
`define CYCLE_DECODE2 4'b0100
`define CYCLE_EXECUTE 4'b1000
`define REG_Z_ADDR    0
`define REG_R1_ADDR   1
`define REG_SW07_ADDR 6
`define REG_SW8_ADDR  7
`endif

module reg_sched #(
  parameter int ADDR_W = `REG_ADDR_SIZE,
  parameter int DATA_W = `REG_SIZE
) (
  input logic        clk,
  input logic        reset,
  reg_sched_if.slave bus
);

  typedef enum logic [2:0] {
    FETCH, DECODE1, DECODE2, EXECUTE, DBG_ACCESS, DBG_DONE
  } state_e;

  state_e            state_q, state_d, out_state;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              writable;
  logic              dbg_slot;

  assign writable = (bus.dbg_addr != ADDR_W'(`REG_SW07_ADDR)) &&
                    (bus.dbg_addr != ADDR_W'(`REG_SW8_ADDR))  &&
                    (bus.dbg_addr != ADDR_W'(`REG_Z_ADDR));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      FETCH:      state_d = DECODE1;
      DECODE1:    state_d = DECODE2;
      DECODE2:    state_d = EXECUTE;
      EXECUTE:    state_d = bus.dbg_req ? DBG_ACCESS : FETCH;
      DBG_ACCESS: begin
        state_d = DBG_DONE;
        err_d   = bus.dbg_we && !writable;
        if (!bus.dbg_we) rdata_d = bus.reg_1;
      end
      DBG_DONE:   state_d = FETCH;
      default:    state_d = FETCH;
    endcase
  end

  // Outputs decode as FETCH while reset is held so no strobe or ack escapes.
  assign out_state = reset ? FETCH : state_q;
  assign dbg_slot  = (out_state == DBG_ACCESS) || (out_state == DBG_DONE);

  always_comb begin
    bus.cycle = '0;
    bus.wr_en = 1'b0;
    case (out_state)
      FETCH:      bus.cycle = `CYCLE_FETCH;
      DECODE1:    bus.cycle = `CYCLE_DECODE1;
      DECODE2:    bus.cycle = `CYCLE_DECODE2;
      EXECUTE: begin
        bus.cycle = `CYCLE_EXECUTE;
        bus.wr_en = bus.cpu_wr_en;
      end
      DBG_ACCESS: bus.wr_en = bus.dbg_we && writable;
      default:    bus.cycle = '0;
    endcase
  end

  assign bus.reg1_addr = dbg_slot ? bus.dbg_addr  : bus.cpu_reg1_addr;
  assign bus.reg2_addr = dbg_slot ? bus.dbg_addr  : bus.cpu_reg2_addr;
  assign bus.wr_addr   = dbg_slot ? bus.dbg_addr  : bus.cpu_wr_addr;
  assign bus.wr_data   = dbg_slot ? bus.dbg_wdata : bus.cpu_wr_data;
  assign bus.dbg_ack   = (out_state == DBG_DONE);
  assign bus.dbg_err   = bus.dbg_ack && err_q;
  assign bus.dbg_rdata = rdata_q;

endmodule

// File: tb/tb_reg_sched.sv
// Directed vector bench for reg_sched with a small register-file model on the regs port.
module tb_reg_sched;

  localparam logic [3:0] CF = 4'b0001, C1 = 4'b0010, C2 = 4'b0100, CE = 4'b1000, CD = 4'b0000;
  localparam logic [2:0] CPU_RA1 = 3'd2, CPU_RA2 = 3'd4, CPU_WA = 3'd3;
  localparam logic [7:0] CPU_WD = 8'h11, SW07 = 8'h5A;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  reg_sched_if #(.ADDR_W(3), .DATA_W(8)) bus ();
  reg_sched #(.ADDR_W(3), .DATA_W(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // Register file: 0 reads zero, 6/7 are switch inputs, 1..5 writable.
  logic [7:0] rf [8];
  logic [7:0] rd1;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h10 + 8'(i);
    end else if (bus.wr_en && bus.wr_addr >= 3'd1 && bus.wr_addr <= 3'd5) begin
      rf[bus.wr_addr] <= bus.wr_data;
    end
  end
  always_comb begin
    rd1 = rf[bus.reg1_addr];
    case (bus.reg1_addr)
      3'd0:    rd1 = 8'h00;
      3'd6:    rd1 = SW07;
      3'd7:    rd1 = 8'h01;
      default: rd1 = rf[bus.reg1_addr];
    endcase
  end
  assign bus.reg_1 = rd1;

  typedef struct {
    logic       rq, we;
    logic [2:0] da;
    logic [7:0] dw;
    logic       cwe;
    logic [3:0] cyc;
    logic       wen, ack, err;
    logic [7:0] rd;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic rq, logic we, logic [2:0] da, logic [7:0] dw, logic cwe,
                              logic [3:0] cyc, logic wen, logic ack, logic err, logic [7:0] rd);
    vec_t v;
    v.rq = rq; v.we = we; v.da = da; v.dw = dw; v.cwe = cwe;
    v.cyc = cyc; v.wen = wen; v.ack = ack; v.err = err; v.rd = rd;
    return v;
  endfunction

  // One CPU instruction with debug inputs held constant; wr_en only in EXECUTE.
  task automatic cpu4(logic rq, logic we, logic [2:0] da, logic [7:0] dw, logic cwe, logic [7:0] rd);
    tbl.push_back(mk(rq, we, da, dw, cwe, CF, 1'b0, 1'b0, 1'b0, rd));
    tbl.push_back(mk(rq, we, da, dw, cwe, C1, 1'b0, 1'b0, 1'b0, rd));
    tbl.push_back(mk(rq, we, da, dw, cwe, C2, 1'b0, 1'b0, 1'b0, rd));
    tbl.push_back(mk(rq, we, da, dw, cwe, CE, cwe,  1'b0, 1'b0, rd));
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    bus.cpu_reg1_addr = CPU_RA1;
    bus.cpu_reg2_addr = CPU_RA2;
    bus.cpu_wr_addr   = CPU_WA;
    bus.cpu_wr_data   = CPU_WD;
    bus.cpu_wr_en     = 1'b0;
    bus.dbg_req       = 1'b0;
    bus.dbg_we        = 1'b0;
    bus.dbg_addr      = 3'd0;
    bus.dbg_wdata     = 8'h00;

    // Idle instructions, CPU write of 0x11 to R3 in the first one.
    cpu4(0, 0, 3'd0, 8'h00, 1, 8'h00);
    cpu4(0, 0, 3'd0, 8'h00, 0, 8'h00);
    // Debug write A5 to R1, raised in DECODE1, held through the ack cycle.
    tbl.push_back(mk(0, 0, 3'd0, 8'h00, 0, CF, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 1, 3'd1, 8'hA5, 0, C1, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 1, 3'd1, 8'hA5, 0, C2, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 1, 3'd1, 8'hA5, 0, CE, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 1, 3'd1, 8'hA5, 0, CD, 1, 0, 0, 8'h00));
    tbl.push_back(mk(1, 1, 3'd1, 8'hA5, 0, CD, 0, 1, 0, 8'h00));
    // Debug read of R1, raised in DECODE1.
    tbl.push_back(mk(0, 0, 3'd0, 8'h00, 0, CF, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 3'd1, 8'h00, 0, C1, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 3'd1, 8'h00, 0, C2, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 3'd1, 8'h00, 0, CE, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 3'd1, 8'h00, 0, CD, 0, 0, 0, 8'h00));
    tbl.push_back(mk(1, 0, 3'd1, 8'h00, 0, CD, 0, 1, 0, 8'hA5));
    // Write to switch address is dropped with an error.
    cpu4(1, 1, 3'd6, 8'h3C, 0, 8'hA5);
    tbl.push_back(mk(1, 1, 3'd6, 8'h3C, 0, CD, 0, 0, 0, 8'hA5));
    tbl.push_back(mk(1, 1, 3'd6, 8'h3C, 0, CD, 0, 1, 1, 8'hA5));
    // Switch readback unchanged.
    cpu4(1, 0, 3'd6, 8'h00, 0, 8'hA5);
    tbl.push_back(mk(1, 0, 3'd6, 8'h00, 0, CD, 0, 0, 0, 8'hA5));
    tbl.push_back(mk(1, 0, 3'd6, 8'h00, 0, CD, 0, 1, 0, SW07));
    // Request held for three instructions: one debug pair after each EXECUTE.
    cpu4(1, 0, 3'd3, 8'h00, 0, SW07);
    tbl.push_back(mk(1, 0, 3'd3, 8'h00, 0, CD, 0, 0, 0, SW07));
    tbl.push_back(mk(1, 0, 3'd3, 8'h00, 0, CD, 0, 1, 0, CPU_WD));
    for (int k = 0; k < 2; k++) begin
      cpu4(1, 0, 3'd3, 8'h00, 0, CPU_WD);
      tbl.push_back(mk(1, 0, 3'd3, 8'h00, 0, CD, 0, 0, 0, CPU_WD));
      tbl.push_back(mk(1, 0, 3'd3, 8'h00, 0, CD, 0, 1, 0, CPU_WD));
    end
    cpu4(0, 0, 3'd0, 8'h00, 0, CPU_WD);
    tbl.push_back(mk(0, 0, 3'd0, 8'h00, 0, CF, 0, 0, 0, CPU_WD));

    tick();
    tick();
    #2;
    chk("rst_cycle", 32'(bus.cycle), 32'(CF));
    chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
    chk("rst_ack", 32'(bus.dbg_ack), 32'd0);
    chk("rst_err", 32'(bus.dbg_err), 32'd0);
    chk("rst_rdata", 32'(bus.dbg_rdata), 32'd0);

    foreach (tbl[i]) begin
      tick();
      reset         = 1'b0;
      bus.dbg_req   = tbl[i].rq;
      bus.dbg_we    = tbl[i].we;
      bus.dbg_addr  = tbl[i].da;
      bus.dbg_wdata = tbl[i].dw;
      bus.cpu_wr_en = tbl[i].cwe;
      #2;
      chk($sformatf("v%0d_cycle", i), 32'(bus.cycle), 32'(tbl[i].cyc));
      chk($sformatf("v%0d_wr_en", i), 32'(bus.wr_en), 32'(tbl[i].wen));
      chk($sformatf("v%0d_ack", i), 32'(bus.dbg_ack), 32'(tbl[i].ack));
      chk($sformatf("v%0d_err", i), 32'(bus.dbg_err), 32'(tbl[i].err));
      chk($sformatf("v%0d_rdata", i), 32'(bus.dbg_rdata), 32'(tbl[i].rd));
      chk($sformatf("v%0d_reg1_addr", i), 32'(bus.reg1_addr),
          32'((tbl[i].cyc == CD) ? tbl[i].da : CPU_RA1));
      chk($sformatf("v%0d_reg2_addr", i), 32'(bus.reg2_addr),
          32'((tbl[i].cyc == CD) ? tbl[i].da : CPU_RA2));
      chk($sformatf("v%0d_wr_addr", i), 32'(bus.wr_addr),
          32'((tbl[i].cyc == CD) ? tbl[i].da : CPU_WA));
      chk($sformatf("v%0d_wr_data", i), 32'(bus.wr_data),
          32'((tbl[i].cyc == CD) ? tbl[i].dw : CPU_WD));
    end

    // Reset during the DBG_ACCESS of a read abandons it.
    tick();
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 3'd1;
    #2 chk("ra_d1", 32'(bus.cycle), 32'(C1));
    tick();
    tick();
    #2 chk("ra_exec", 32'(bus.cycle), 32'(CE));
    tick();
    #2 chk("ra_access", 32'(bus.cycle), 32'(CD));
    reset = 1'b1;
    #2;
    chk("ra_rst_cycle", 32'(bus.cycle), 32'(CF));
    chk("ra_rst_ack", 32'(bus.dbg_ack), 32'd0);
    chk("ra_rst_wr_en", 32'(bus.wr_en), 32'd0);
    tick();
    reset = 1'b0;
    bus.dbg_req = 1'b0;
    #2;
    chk("ra_post_cycle", 32'(bus.cycle), 32'(CF));
    chk("ra_post_ack", 32'(bus.dbg_ack), 32'd0);
    chk("ra_post_rdata", 32'(bus.dbg_rdata), 32'd0);
    tick();
    #2;
    chk("ra_next_cycle", 32'(bus.cycle), 32'(C1));
    chk("ra_next_ack", 32'(bus.dbg_ack), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_sched.md
REG_SCHED -- requirements
Module: reg_sched

Interface
REQ-001 Parameter ADDR_W, default 3, register address width; SHALL match `REG_ADDR_SIZE.
REQ-002 Parameter DATA_W, default 8, register data width; SHALL match `REG_SIZE.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 cpu_reg1_addr, cpu_reg2_addr, cpu_wr_addr  in  ADDR_W each  CPU read and write addresses.
REQ-006 cpu_wr_data  in  DATA_W  CPU write data; cpu_wr_en  in  1  CPU write request for this instruction.
REQ-007 dbg_req  in  1  debug transaction request.
REQ-008 dbg_we  in  1  1 = write, 0 = read.
REQ-009 dbg_addr  in  ADDR_W  debug register address; dbg_wdata  in  DATA_W  debug write data.
REQ-010 dbg_ack  out  1  one-cycle transaction-complete pulse.
REQ-011 dbg_err  out  1  valid with dbg_ack; set when a write was dropped.
REQ-012 dbg_rdata  out  DATA_W  registered read result.
REQ-013 reg1_addr, reg2_addr, wr_addr  out  ADDR_W  regs port addresses; wr_data  out  DATA_W; wr_en  out  1  regs write strobe.
REQ-014 reg_1  in  DATA_W  regs read port 1 data.
REQ-015 cycle  out  `CYCLE_SIZE  one-hot CPU phase; all-zero while the debug port owns regs.

Function
REQ-016 FSM states SHALL be FETCH, DECODE1, DECODE2, EXECUTE, DBG_ACCESS, DBG_DONE.
REQ-017 Transitions: FETCH->DECODE1->DECODE2->EXECUTE, one cycle each.
REQ-018 From EXECUTE: dbg_req=1 -> DBG_ACCESS; dbg_req=0 -> FETCH.
REQ-019 DBG_ACCESS->DBG_DONE->FETCH unconditionally; at most one debug transaction SHALL be inserted per instruction, so the CPU is never starved.
REQ-020 cycle SHALL be `CYCLE_FETCH/DECODE1/DECODE2/EXECUTE one-hot in the matching CPU state and 0 in DBG_ACCESS and DBG_DONE.
REQ-021 In CPU states: reg1_addr=cpu_reg1_addr, reg2_addr=cpu_reg2_addr, wr_addr=cpu_wr_addr, wr_data=cpu_wr_data.
REQ-022 In CPU states, wr_en SHALL equal cpu_wr_en during EXECUTE only, so the written value is visible in the following FETCH.
REQ-023 In DBG_ACCESS and DBG_DONE: reg1_addr=reg2_addr=wr_addr=dbg_addr and wr_data=dbg_wdata.
REQ-024 In DBG_ACCESS, wr_en SHALL be dbg_we AND the address is writable; wr_en SHALL be 0 in DBG_DONE.
REQ-025 Non-writable addresses are `REG_SW07_ADDR, `REG_SW8_ADDR and `REG_Z_ADDR; a debug write to any of them SHALL be dropped and SHALL set dbg_err=1 with dbg_ack.
REQ-026 On the edge leaving DBG_ACCESS, dbg_rdata SHALL load reg_1 for a read and hold its previous value for a write.
REQ-027 dbg_ack SHALL be 1 for exactly the DBG_DONE cycle; dbg_err SHALL be 0 whenever dbg_ack=0.
REQ-028 Debug read-after-write latency: data SHALL be visible to the CPU from the next FETCH.
REQ-029 Handshake: the requester SHALL hold dbg_req, dbg_we, dbg_addr and dbg_wdata stable until dbg_ack.
REQ-030 dbg_req still high in the DBG_DONE cycle SHALL be treated as a new request, sampled at the next EXECUTE.
REQ-031 dbg_req rising outside EXECUTE SHALL wait, with no effect, until the EXECUTE->next edge.
REQ-032 A debug read SHALL return the same value the CPU sees for that address, including switch-mapped addresses.

Reset
REQ-033 Reset SHALL force state=FETCH, cycle=`CYCLE_FETCH one-hot, wr_en=0, dbg_ack=0, dbg_err=0, dbg_rdata=0.
REQ-034 Reset in DBG_ACCESS or DBG_DONE SHALL abandon the transaction with no dbg_ack; a write strobed before reset stands.
REQ-035 Reset SHALL take priority over every transition.

Verification
REQ-036 Reset then 8 idle clocks, dbg_req=0 -> cycle steps FETCH,D1,D2,EXEC twice; wr_en high only in EXEC when cpu_wr_en=1.
REQ-037 dbg_req=1, we=1, addr=`REG_R1_ADDR, wdata=8'hA5, raised in DECODE1 -> DBG_ACCESS follows EXEC; wr_en=1 there, wr_addr=R1; dbg_ack=1 and dbg_err=0 in DBG_DONE; regs R1=8'hA5 at next FETCH.
REQ-038 Debug read of `REG_R1_ADDR after REQ-037 -> dbg_rdata=8'hA5 with dbg_ack; cycle=0 during both debug states.
REQ-039 Debug write 8'h3C to `REG_SW07_ADDR -> wr_en stays 0, dbg_ack=1 with dbg_err=1, switch readback unchanged.
REQ-040 dbg_req held high continuously for 3 instructions -> exactly one debug pair after each EXEC; every FETCH..EXEC sequence still completes.
REQ-041 Reset asserted during DBG_ACCESS of a read -> no dbg_ack, dbg_rdata=0, cycle=FETCH on the cycle after reset.
